// File: rtl/aes_decipher_if.sv
// aes_decipher_if: request/result bundle between a host (master) and aes_decipher (slave).
interface aes_decipher_if #(
    parameter int SENTENCE = 128
);
    logic                Start;
    logic [SENTENCE-1:0] Cipher_Text;
    logic [SENTENCE-1:0] Key;
    logic [SENTENCE-1:0] Plain_Text;
    logic                Done;
    logic                Busy;
    modport master (output Start, Cipher_Text, Key, input Plain_Text, Done, Busy);
    modport slave  (input Start, Cipher_Text, Key, output Plain_Text, Done, Busy);
endinterface

// File: rtl/aes_decipher.sv
// aes_decipher: iterative AES-128 inverse cipher, one round per clock, round keys derived on the fly.
// Define AES_DEC_KEYCACHE_EN to cache the last key and its round key 10 so a repeated key skips KEYEXP.
module aes_decipher #(
    parameter int BYTE     = 8,
    parameter int WORD     = 32,
    parameter int SENTENCE = 128
) (
    input logic           CLK,
    input logic           RST_N,
    aes_decipher_if.slave bus
);
    typedef enum logic [2:0] {IDLE, KEYEXP, ROUND0, ROUNDS, FINAL} state_t;
    state_t              state, state_nxt;
    logic [3:0]          cnt, rcon_sel;
    logic [SENTENCE-1:0] blk, rk, rk_nxt, rnd, cache_rk;
    logic [WORD-1:0]     w0, w1, w2, w3, sub_in, sub_out, rc;
    logic                hit;

    function automatic logic [BYTE-1:0] gmul(input logic [BYTE-1:0] a, input logic [BYTE-1:0] b);
        logic [BYTE-1:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < BYTE; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[BYTE-2:0], 1'b0} ^ (x[BYTE-1] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 by an addition chain; 0 maps to 0.
    function automatic logic [BYTE-1:0] ginv(input logic [BYTE-1:0] a);
        logic [BYTE-1:0] a2, a3, a6, a12, t;
        a2  = gmul(a, a);
        a3  = gmul(a2, a);
        a6  = gmul(a3, a3);
        a12 = gmul(a6, a6);
        t   = gmul(a12, a3);
        for (int i = 0; i < 4; i++) t = gmul(t, t);
        return gmul(gmul(t, a12), a2);
    endfunction

    function automatic logic [BYTE-1:0] rotl(input logic [BYTE-1:0] x, input int n);
        return (x << n) | (x >> (BYTE - n));
    endfunction

    function automatic logic [BYTE-1:0] sbox(input logic [BYTE-1:0] a);
        logic [BYTE-1:0] b;
        b = ginv(a);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [BYTE-1:0] inv_sbox(input logic [BYTE-1:0] a);
        return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [BYTE-1:0] rcon_of(input logic [3:0] i);
        logic [BYTE-1:0] r;
        r = 8'h01;
        for (int j = 1; j < 10; j++) r = j < int'(i) ? gmul(r, 8'h02) : r;
        return r;
    endfunction

    function automatic logic [BYTE-1:0] sb(input logic [SENTENCE-1:0] s, input int i);
        return s[SENTENCE-1-BYTE*i -: BYTE];
    endfunction

    // Byte i of the block is row i%4 of column i/4, most significant byte first.
    function automatic logic [SENTENCE-1:0] inv_round(input logic [SENTENCE-1:0] s, input logic [SENTENCE-1:0] k,
                                                      input logic mix);
        logic [SENTENCE-1:0] t, o;
        t = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[SENTENCE-1-BYTE*(4*c+r) -: BYTE] = inv_sbox(sb(s, 4*((c-r+4)%4)+r));
        t = t ^ k;
        o = t;
        if (mix)
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    o[SENTENCE-1-BYTE*(4*c+r) -: BYTE] = gmul(sb(t, 4*c+r), 8'h0e) ^
                        gmul(sb(t, 4*c+(r+1)%4), 8'h0b) ^ gmul(sb(t, 4*c+(r+2)%4), 8'h0d) ^
                        gmul(sb(t, 4*c+(r+3)%4), 8'h09);
        return o;
    endfunction

    assign {w0, w1, w2, w3} = rk;
    assign rcon_sel = state == KEYEXP ? cnt + 4'd1 : state == ROUND0 ? 4'd10 : cnt;
    assign rc       = {rcon_of(rcon_sel), {(WORD-BYTE){1'b0}}};
    // Forward steps rotate the current w[3]; inverse steps need the recovered previous w[3].
    assign sub_in   = state == KEYEXP ? w3 : w3 ^ w2;
    assign sub_out  = {sbox(sub_in[23:16]), sbox(sub_in[15:8]), sbox(sub_in[7:0]), sbox(sub_in[31:24])};
    assign rk_nxt   = state == KEYEXP
        ? {w0 ^ sub_out ^ rc, w1 ^ w0 ^ sub_out ^ rc, w2 ^ w1 ^ w0 ^ sub_out ^ rc, w3 ^ w2 ^ w1 ^ w0 ^ sub_out ^ rc}
        : {w0 ^ sub_out ^ rc, w1 ^ w0, w2 ^ w1, w3 ^ w2};
    assign rnd      = inv_round(blk, rk, state == ROUNDS);
    assign bus.Busy = state != IDLE;

`ifdef AES_DEC_KEYCACHE_EN
    logic [SENTENCE-1:0] cache_key;
    logic                cache_vld;
    assign hit = cache_vld && bus.Key == cache_key;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cache_vld <= 1'b0;
            cache_key <= '0;
            cache_rk  <= '0;
        end else if (state == IDLE && bus.Start && !hit) begin
            cache_vld <= 1'b0;
            cache_key <= bus.Key;
        end else if (state == KEYEXP && cnt == 4'd9) begin
            cache_vld <= 1'b1;
            cache_rk  <= rk_nxt;
        end
    end
`else
    assign hit      = 1'b0;
    assign cache_rk = '0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE   ? (bus.Start ? (hit ? ROUND0 : KEYEXP) : IDLE) :
                    state == KEYEXP ? (cnt == 4'd9 ? ROUND0 : KEYEXP) :
                    state == ROUND0 ? ROUNDS :
                    state == ROUNDS ? (cnt == 4'd1 ? FINAL : ROUNDS) : IDLE;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            blk            <= '0;
            rk             <= '0;
            cnt            <= '0;
            bus.Plain_Text <= '0;
            bus.Done       <= 1'b0;
        end else begin
            bus.Done <= state == FINAL;
            case (state)
                IDLE: if (bus.Start) begin
                    blk <= bus.Cipher_Text;
                    rk  <= hit ? cache_rk : bus.Key;
                    cnt <= '0;
                end
                KEYEXP: begin
                    rk  <= rk_nxt;
                    cnt <= cnt + 4'd1;
                end
                ROUND0: begin
                    blk <= blk ^ rk;
                    rk  <= rk_nxt;
                    cnt <= 4'd9;
                end
                ROUNDS: begin
                    blk <= rnd;
                    rk  <= rk_nxt;
                    cnt <= cnt - 4'd1;
                end
                default: bus.Plain_Text <= rnd;
            endcase
        end
    end
endmodule
